// File: rtl/hydra_pkg.sv
// hydra_pkg: shared scheduler constants, FSM state type and WRR weight helper.
package hydra_pkg;
    localparam int NUM_PRIOR = 8;
    localparam int PRIOR_W   = 3;
    localparam int CREDIT_W  = 4;
    typedef enum logic [1:0] {ARB, ISSUE, BUSY} sched_state_t;
    function automatic logic [CREDIT_W-1:0] wrr_weight(input int p);
        return CREDIT_W'(NUM_PRIOR - p);
    endfunction
endpackage

// File: rtl/prior_picker.sv
// prior_picker: combinational find-first-set; lowest set index wins.
module prior_picker import hydra_pkg::*; (
    input  logic [NUM_PRIOR-1:0] mask,
    output logic                 any,
    output logic [PRIOR_W-1:0]   idx
);
    assign any = |mask;
    always_comb begin
        idx = '0;
        for (int i = NUM_PRIOR - 1; i >= 0; i--) if (mask[i]) idx = PRIOR_W'(i);
    end
endmodule

// File: rtl/port_scheduler.sv
// port_scheduler: per-port strict-priority / WRR dequeue scheduler with
// valid/ack offer to the read engine and hold-off until the packet is read.
module port_scheduler import hydra_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrr_en,
    input  logic [NUM_PRIOR-1:0] queue_not_empty,
    input  logic                 ready,
    output logic                 issue_vld,
    output logic [PRIOR_W-1:0]   issue_prior,
    input  logic                 issue_ack,
    input  logic                 pkt_done,
    output logic                 busy
);
    sched_state_t         state_q, state_d;
    logic [PRIOR_W-1:0]   prior_q, prior_d;
    logic [CREDIT_W-1:0]  credit_q [NUM_PRIOR];
    logic [CREDIT_W-1:0]  credit_d [NUM_PRIOR];
    logic                 wrr_q;
    logic [NUM_PRIOR-1:0] eligible;
    logic                 any;
    logic [PRIOR_W-1:0]   idx;
    logic                 reload, dec;
    always_comb begin
        for (int p = 0; p < NUM_PRIOR; p++)
            eligible[p] = queue_not_empty[p] & (~wrr_en | (credit_q[p] != '0));
    end
    prior_picker u_pick (.mask(eligible), .any(any), .idx(idx));
    // Reload on a registered 0->1 of wrr_en, or at end of round (work pending, no credit left).
    assign reload = (wrr_en & ~wrr_q)
                  | ((state_q == ARB) & wrr_en & ready & (|queue_not_empty) & ~any);
    assign dec    = (state_q == ISSUE) & issue_ack & wrr_en & (credit_q[prior_q] != '0);
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (ready & any) state_d = ISSUE;
            ISSUE:   if (issue_ack) state_d = BUSY;
                     else if (!queue_not_empty[prior_q]) state_d = ARB;
            BUSY:    if (pkt_done) state_d = ARB;
            default: state_d = ARB;
        endcase
        prior_d = ((state_q == ARB) & ready & any) ? idx : prior_q;
        for (int p = 0; p < NUM_PRIOR; p++)
            credit_d[p] = reload ? wrr_weight(p)
                        : (dec & (prior_q == PRIOR_W'(p))) ? credit_q[p] - 1'b1
                        : credit_q[p];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            prior_q <= '0;
            wrr_q   <= 1'b0;
            for (int p = 0; p < NUM_PRIOR; p++) credit_q[p] <= wrr_weight(p);
        end else begin
            state_q  <= state_d;
            prior_q  <= prior_d;
            wrr_q    <= wrr_en;
            credit_q <= credit_d;
        end
    end
    assign issue_vld   = (state_q == ISSUE);
    assign busy        = (state_q == BUSY);
    assign issue_prior = prior_q;
endmodule

// File: tb/tb_port_scheduler.sv
// tb_port_scheduler: directed scenarios plus randomized traffic checked
// every cycle against a behavioural scheduler model.
module tb_port_scheduler;
    import hydra_pkg::*;
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wrr_en = 1'b0;
    logic [NUM_PRIOR-1:0] qne = '0;
    logic                 ready = 1'b0;
    logic                 issue_ack = 1'b0;
    logic                 pkt_done = 1'b0;
    logic                 issue_vld, busy;
    logic [PRIOR_W-1:0]   issue_prior;
    int checks = 0;
    int errors = 0;
    int  cr [NUM_PRIOR];
    bit  m_offer, m_busy, m_wprev;
    int  m_prior;
    int  seq [$];

    port_scheduler dut (
        .clk(clk), .rst(rst), .wrr_en(wrr_en), .queue_not_empty(qne), .ready(ready),
        .issue_vld(issue_vld), .issue_prior(issue_prior), .issue_ack(issue_ack),
        .pkt_done(pkt_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NUM_PRIOR; p++) cr[p] = NUM_PRIOR - p;
        m_offer = 0; m_busy = 0; m_prior = 0; m_wprev = 0;
    endtask

    // One clock of the scheduler, stated from the rules rather than the RTL structure.
    task automatic model_step();
        int  pick = -1;
        int  dec_q = -1;
        bit  refill = wrr_en && !m_wprev;
        if (!m_offer && !m_busy) begin
            for (int p = NUM_PRIOR - 1; p >= 0; p--)
                if (qne[p] && (!wrr_en || cr[p] > 0)) pick = p;
            if (ready && pick >= 0) begin
                m_offer = 1; m_prior = pick;
            end else if (wrr_en && ready && qne != 0 && pick < 0) refill = 1;
        end else if (m_offer) begin
            if (issue_ack) begin
                m_offer = 0; m_busy = 1;
                if (wrr_en && cr[m_prior] > 0) dec_q = m_prior;
            end else if (!qne[m_prior]) m_offer = 0;
        end else if (pkt_done) m_busy = 0;
        if (refill) for (int p = 0; p < NUM_PRIOR; p++) cr[p] = NUM_PRIOR - p;
        else if (dec_q >= 0) cr[dec_q]--;
        m_wprev = wrr_en;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset(); else model_step();
        #1;
        if (!rst) begin
            chk("model_vld", int'(issue_vld), int'(m_offer));
            chk("model_busy", int'(busy), int'(m_busy));
            if (m_offer) chk("model_prior", int'(issue_prior), m_prior);
            for (int p = 0; p < NUM_PRIOR; p++) chk("model_credit", int'(dut.credit_q[p]), cr[p]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; wrr_en = 0; qne = '0; ready = 0; issue_ack = 0; pkt_done = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        // 1: strict priority picks lowest set bit, and again after the packet completes
        do_reset();
        qne = 8'b1010_0100; ready = 1;
        tick(); chk("t1_vld", int'(issue_vld), 1); chk("t1_prior", int'(issue_prior), 2);
        issue_ack = 1;
        tick(); chk("t1_busy", int'(busy), 1); chk("t1_vld_off", int'(issue_vld), 0);
        issue_ack = 0; pkt_done = 1;
        tick(); chk("t1_done", int'(busy), 0); chk("t1_no_b2b", int'(issue_vld), 0);
        pkt_done = 0;
        tick(); chk("t1_reissue_vld", int'(issue_vld), 1); chk("t1_reissue", int'(issue_prior), 2);

        // 2: WRR rounds of 8x prio0 + 1x prio7
        do_reset();
        wrr_en = 1; qne = 8'h81; ready = 1;
        seq.delete();
        for (int c = 0; c < 400 && seq.size() < 20; c++) begin
            tick();
            pkt_done = busy;
            issue_ack = issue_vld;
            if (issue_vld) seq.push_back(int'(issue_prior));
        end
        issue_ack = 0; pkt_done = 0;
        chk("t2_count", seq.size(), 20);
        foreach (seq[i]) chk("t2_order", seq[i], (i % 9 < 8) ? 0 : 7);

        // 3: no offer while ready is low
        do_reset();
        qne = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("t3_hold", int'(issue_vld), 0);
        end
        ready = 1;
        tick(); chk("t3_vld", int'(issue_vld), 1); chk("t3_prior", int'(issue_prior), 0);

        // 4: abort without ack keeps credit; ack wins over abort
        do_reset();
        wrr_en = 1; qne = 8'h08; ready = 1;
        tick(); chk("t4_vld", int'(issue_vld), 1); chk("t4_prior", int'(issue_prior), 3);
        qne = '0;
        tick(); chk("t4_abort", int'(issue_vld), 0); chk("t4_credit", int'(dut.credit_q[3]), 5);
        qne = 8'h08;
        tick(); chk("t4_reoffer", int'(issue_vld), 1);
        qne = '0; issue_ack = 1;
        tick(); chk("t4_ack_busy", int'(busy), 1); chk("t4_ack_credit", int'(dut.credit_q[3]), 4);
        issue_ack = 0; pkt_done = 1;
        tick(); pkt_done = 0;

        // 5: wrr_en 1->0->1 reloads credits
        do_reset();
        wrr_en = 1; qne = 8'h02;
        for (int k = 0; k < 3; k++) begin
            ready = 1;
            tick(); ready = 0; issue_ack = 1;
            tick(); issue_ack = 0; pkt_done = 1;
            tick(); pkt_done = 0;
        end
        chk("t5_credit_used", int'(dut.credit_q[1]), 4);
        wrr_en = 0; tick(); chk("t5_frozen", int'(dut.credit_q[1]), 4);
        wrr_en = 1; tick(); chk("t5_reload", int'(dut.credit_q[1]), 7);

        // 6: asynchronous reset while busy
        do_reset();
        qne = 8'h01; ready = 1;
        tick(); issue_ack = 1; ready = 0;
        tick(); issue_ack = 0; chk("t6_busy", int'(busy), 1);
        rst = 1; #1;
        chk("t6_rst_vld", int'(issue_vld), 0); chk("t6_rst_busy", int'(busy), 0);
        for (int p = 0; p < NUM_PRIOR; p++) chk("t6_rst_credit", int'(dut.credit_q[p]), NUM_PRIOR - p);
        tick(); rst = 0; qne = '0; pkt_done = 1;
        tick(); pkt_done = 0;
        chk("t6_ignore_done", int'(busy), 0); chk("t6_idle", int'(issue_vld), 0);

        // randomized traffic, checked by the per-cycle compare process
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 49) == 0) wrr_en = ~wrr_en;
            if ($urandom_range(0, 3) == 0) qne = NUM_PRIOR'($urandom);
            ready     = ($urandom_range(0, 4) != 0);
            issue_ack = 1'($urandom_range(0, 1));
            pkt_done  = ($urandom_range(0, 3) == 0);
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
